// File: rtl/pipe_pkg.sv
// ============================================================================
// Module  : pipe_pkg
// Purpose : Shared widths, FSM state type and ALU funct codes for the ID/EX stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_OP_W   = 6;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_e;

    localparam logic [DEF_OP_W-1:0] ALU_ADD  = 6'b100000;
    localparam logic [DEF_OP_W-1:0] ALU_ADDU = 6'b100001;
    localparam logic [DEF_OP_W-1:0] ALU_SUB  = 6'b100010;
    localparam logic [DEF_OP_W-1:0] ALU_SUBU = 6'b100011;
    localparam logic [DEF_OP_W-1:0] ALU_AND  = 6'b100100;
    localparam logic [DEF_OP_W-1:0] ALU_OR   = 6'b100101;
    localparam logic [DEF_OP_W-1:0] ALU_XOR  = 6'b100110;
    localparam logic [DEF_OP_W-1:0] ALU_NOR  = 6'b100111;
    localparam logic [DEF_OP_W-1:0] ALU_SLT  = 6'b101010;
    localparam logic [DEF_OP_W-1:0] ALU_SLTU = 6'b101011;

endpackage

`default_nettype wire

// File: rtl/fwd_mux.sv
// ============================================================================
// Module  : fwd_mux
// Purpose : Single-operand forwarding selector (MEM over WB over latched value).
//           Build option: ID_EX_FORWARD_EN enables forwarding.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_mux
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic [REG_W-1:0]  src_num,
    input  logic [DATA_W-1:0] reg_val,
    input  logic [REG_W-1:0]  mem_dest,
    input  logic              mem_reg_write,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] fwd_val
);

`ifdef ID_EX_FORWARD_EN
    logic mem_hit;
    logic wb_hit;

    // $0 is hard-wired, so it can never be a forwarding source
    assign mem_hit = mem_reg_write && (mem_dest == src_num) && (src_num != '0);
    assign wb_hit  = wb_reg_write  && (wb_dest  == src_num) && (src_num != '0);

    always_comb begin
        fwd_val = reg_val;
        if (mem_hit) begin
            fwd_val = mem_result;
        end else if (wb_hit) begin
            fwd_val = wb_result;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{src_num, mem_dest, mem_reg_write, mem_result,
                          wb_dest, wb_reg_write, wb_result};
    assign fwd_val    = reg_val;
`endif

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module  : id_ex_stage
// Purpose : ID/EX pipeline register and ALU operand issue with load-use bubbles.
//           Build option: ID_EX_FORWARD_EN adds MEM/WB operand forwarding.
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic              id_uses_rt,
    input  logic [REG_W-1:0]  id_rs_num,
    input  logic [REG_W-1:0]  id_rt_num,
    input  logic [REG_W-1:0]  id_dest,
    input  logic [OP_W-1:0]   id_operation,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [REG_W-1:0]  mem_dest,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [OP_W-1:0]   ex_operation,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_valid,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  stall_count
);

    state_e              state_q;
    logic                ex_valid_q;
    logic                ex_reg_write_q;
    logic                ex_mem_read_q;
    logic                ex_mem_write_q;
    logic [REG_W-1:0]    ex_dest_q;
    logic [REG_W-1:0]    ex_rs_num_q;
    logic [REG_W-1:0]    ex_rt_num_q;
    logic [OP_W-1:0]     ex_operation_q;
    logic [DATA_W-1:0]   rs_data_q;
    logic [DATA_W-1:0]   rt_data_q;
    logic [DATA_W-1:0]   imm_q;
    logic                use_imm_q;
    logic [CNT_W-1:0]    stall_count_q;

    logic                ex_writes;
    logic                ex_src_hit;
    logic                hazard;
    logic                load;
    logic [DATA_W-1:0]   fwd_rs;
    logic [DATA_W-1:0]   fwd_rt;

    assign ex_writes  = ex_valid_q && ex_reg_write_q && (ex_dest_q != '0);
    assign ex_src_hit = (ex_dest_q == id_rs_num) ||
                        (id_uses_rt && (ex_dest_q == id_rt_num));

`ifdef ID_EX_FORWARD_EN
    assign hazard = ex_writes && ex_mem_read_q && ex_src_hit;
`else
    logic mem_src_hit;

    // Without forwarding any pending EX/MEM write must drain; WB is covered by the write-first register file
    assign mem_src_hit = mem_reg_write && (mem_dest != '0) &&
                         ((mem_dest == id_rs_num) ||
                          (id_uses_rt && (mem_dest == id_rt_num)));
    assign hazard      = (ex_writes && ex_src_hit) || mem_src_hit;
`endif

    assign load = id_valid && !hazard;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_RUN;
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_dest_q      <= '0;
            ex_rs_num_q    <= '0;
            ex_rt_num_q    <= '0;
            ex_operation_q <= '0;
            rs_data_q      <= '0;
            rt_data_q      <= '0;
            imm_q          <= '0;
            use_imm_q      <= 1'b0;
            stall_count_q  <= '0;
        end else if (flush) begin
            state_q        <= ST_RUN;
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
        end else if (!stall) begin
            case (state_q)
                ST_RUN:    if (hazard)  state_q <= ST_BUBBLE;
                ST_BUBBLE: if (!hazard) state_q <= ST_RUN;
                default:   state_q <= ST_RUN;
            endcase

            if (hazard && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end

            ex_valid_q     <= load;
            ex_reg_write_q <= load && id_reg_write;
            ex_mem_read_q  <= load && id_mem_read;
            ex_mem_write_q <= load && id_mem_write;

            if (load) begin
                ex_dest_q      <= id_dest;
                ex_rs_num_q    <= id_rs_num;
                ex_rt_num_q    <= id_rt_num;
                ex_operation_q <= id_operation;
                rs_data_q      <= id_rs_data;
                rt_data_q      <= id_rt_data;
                imm_q          <= id_imm;
                use_imm_q      <= id_use_imm;
            end
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
        .src_num       (ex_rs_num_q),
        .reg_val       (rs_data_q),
        .mem_dest      (mem_dest),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_dest       (wb_dest),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .fwd_val       (fwd_rs)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
        .src_num       (ex_rt_num_q),
        .reg_val       (rt_data_q),
        .mem_dest      (mem_dest),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_dest       (wb_dest),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .fwd_val       (fwd_rt)
    );

    assign ex_a          = fwd_rs;
    assign ex_b          = use_imm_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_operation  = ex_operation_q;
    assign ex_dest       = ex_dest_q;
    assign ex_reg_write  = ex_reg_write_q;
    assign ex_mem_read   = ex_mem_read_q;
    assign ex_mem_write  = ex_mem_write_q;
    assign ex_valid      = ex_valid_q;
    assign hazard_stall  = hazard;
    assign stall_count   = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module  : tb_id_ex_stage
// Purpose : Directed self-checking bench for id_ex_stage (both forwarding builds).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int OP_W   = 6;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              stall, flush, id_valid;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
    logic              id_use_imm, id_uses_rt;
    logic [REG_W-1:0]  id_rs_num, id_rt_num, id_dest;
    logic [OP_W-1:0]   id_operation;
    logic              id_reg_write, id_mem_read, id_mem_write;
    logic [REG_W-1:0]  mem_dest, wb_dest;
    logic              mem_reg_write, wb_reg_write;
    logic [DATA_W-1:0] mem_result, wb_result;
    logic [DATA_W-1:0] ex_a, ex_b, ex_store_data;
    logic [OP_W-1:0]   ex_operation;
    logic [REG_W-1:0]  ex_dest;
    logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_valid;
    logic              hazard_stall;
    logic [CNT_W-1:0]  stall_count;

    int                n_checks = 0;
    int                n_errors = 0;
    logic [CNT_W-1:0]  exp_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_uses_rt(id_uses_rt), .id_rs_num(id_rs_num),
        .id_rt_num(id_rt_num), .id_dest(id_dest), .id_operation(id_operation),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .mem_dest(mem_dest), .wb_dest(wb_dest), .mem_reg_write(mem_reg_write),
        .wb_reg_write(wb_reg_write), .mem_result(mem_result), .wb_result(wb_result),
        .ex_a(ex_a), .ex_b(ex_b), .ex_operation(ex_operation), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_valid(ex_valid), .hazard_stall(hazard_stall),
        .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                         input logic [31:0] rtd, input logic [31:0] imm, input logic use_imm,
                         input logic uses_rt, input logic [4:0] dest, input logic [5:0] op,
                         input logic rw, input logic mr, input logic mw);
        id_valid     = 1'b1;
        id_rs_num    = rs;   id_rs_data = rsd;
        id_rt_num    = rt;   id_rt_data = rtd;
        id_imm       = imm;  id_use_imm = use_imm;
        id_uses_rt   = uses_rt;
        id_dest      = dest; id_operation = op;
        id_reg_write = rw;   id_mem_read = mr; id_mem_write = mw;
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        id_valid = 1'b0;
        mem_dest = '0; wb_dest = '0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        mem_result = '0; wb_result = '0;
        exp_cnt = '0;

        // Reset state
        step(); step();
        check("rst_valid", ex_valid, 0);
        check("rst_a", ex_a, 0);
        check("rst_b", ex_b, 0);
        check("rst_op", ex_operation, 0);
        check("rst_cnt", stall_count, 0);
        check("rst_hazard", hazard_stall, 0);
        reset_n = 1'b1;

        // Simple register-register issue
        issue(5, 7, 6, 3, 0, 0, 1, 10, ALU_ADD, 1, 0, 0);
        step();
        check("add_a", ex_a, 7);
        check("add_b", ex_b, 3);
        check("add_op", ex_operation, 32'h20);
        check("add_valid", ex_valid, 1);
        check("add_store", ex_store_data, 3);
        check("add_dest", ex_dest, 10);

        // Immediate operand selection
        issue(1, 100, 2, 55, 32'h1234, 1, 0, 11, ALU_SUB, 1, 0, 0);
        step();
        check("imm_b", ex_b, 32'h1234);
        check("imm_store", ex_store_data, 55);
        check("imm_op", ex_operation, 32'h22);

        // Load-use: LW $8 in EX, next instruction reads $8
        issue(3, 0, 0, 0, 4, 1, 0, 8, ALU_ADD, 1, 1, 0);
        step();
        check("lw_memread", ex_mem_read, 1);
        issue(8, 32'h77, 9, 32'h66, 0, 0, 1, 12, ALU_ADD, 1, 0, 0);
        #1;
        check("lu_hazard", hazard_stall, 1);
        step();
        exp_cnt = exp_cnt + 1'b1;
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_memread", ex_mem_read, 0);
        check("lu_cnt", stall_count, exp_cnt);
        mem_dest = 8; mem_reg_write = 1'b1; mem_result = 32'hBEEF;
        #1;
`ifdef ID_EX_FORWARD_EN
        check("lu_hazard_clear", hazard_stall, 0);
`else
        check("lu_mem_hazard", hazard_stall, 1);
        step();
        exp_cnt = exp_cnt + 1'b1;
        check("lu_bubble2_valid", ex_valid, 0);
        check("lu_cnt2", stall_count, exp_cnt);
        mem_reg_write = 1'b0;
        id_rs_data = 32'hBEEF;
        #1;
        check("lu_hazard_clear", hazard_stall, 0);
`endif
        step();
        check("lu_issue_valid", ex_valid, 1);
        check("lu_issue_a", ex_a, 32'hBEEF);
        check("lu_issue_b", ex_b, 32'h66);
        check("lu_issue_cnt", stall_count, exp_cnt);
        mem_reg_write = 1'b0; mem_dest = '0;

        // Forwarding priority (MEM over WB) or plain latched value without forwarding
        issue(9, 32'h1111, 0, 32'h2222, 0, 0, 1, 13, ALU_ADDU, 1, 0, 0);
        wb_dest = 9; wb_reg_write = 1'b1; wb_result = 32'h5555;
`ifdef ID_EX_FORWARD_EN
        mem_dest = 9; mem_reg_write = 1'b1; mem_result = 32'hAAAA;
`endif
        step();
`ifdef ID_EX_FORWARD_EN
        check("fwd_mem_prio", ex_a, 32'hAAAA);
`else
        check("nofwd_a", ex_a, 32'h1111);
`endif
        check("fwd_rt_zero", ex_b, 32'h2222);

        // Register 0 never forwards nor hazards
        issue(0, 0, 0, 0, 0, 0, 1, 14, ALU_SLT, 1, 0, 0);
        mem_dest = 0; mem_reg_write = 1'b1; mem_result = 32'hAAAA;
        wb_dest = 0;  wb_reg_write = 1'b1;  wb_result = 32'h5555;
        #1;
        check("r0_hazard", hazard_stall, 0);
        step();
        check("r0_a", ex_a, 0);
        check("r0_op", ex_operation, 32'h2A);
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;

        // Flush beats stall
        flush = 1'b1; stall = 1'b1;
        step();
        check("flush_valid", ex_valid, 0);
        check("flush_regwrite", ex_reg_write, 0);
        flush = 1'b0; stall = 1'b0;

        issue(14, 32'h1234_5678, 15, 9, 0, 0, 1, 20, ALU_AND, 1, 0, 0);
        step();
        check("pre_stall_a", ex_a, 32'h1234_5678);
        check("pre_stall_op", ex_operation, 32'h24);

        // External stall holds EX for 3 cycles
        stall = 1'b1;
        issue(16, 32'hDEAD, 17, 1, 0, 0, 1, 21, ALU_SUB, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_a", ex_a, 32'h1234_5678);
            check("stall_valid", ex_valid, 1);
            check("stall_op", ex_operation, 32'h24);
            check("stall_memwrite", ex_mem_write, 0);
            check("stall_cnt", stall_count, exp_cnt);
        end
        stall = 1'b0;

`ifndef ID_EX_FORWARD_EN
        // MEM RAW without forwarding: bubble every cycle, counter saturates
        issue(4, 32'h44, 5, 32'h55, 0, 0, 1, 22, ALU_OR, 1, 0, 0);
        mem_dest = 4; mem_reg_write = 1'b1;
        #1;
        check("raw_hazard", hazard_stall, 1);
        step();
        exp_cnt = exp_cnt + 1'b1;
        check("raw_cnt1", stall_count, exp_cnt);
        step();
        exp_cnt = exp_cnt + 1'b1;
        check("raw_cnt2", stall_count, exp_cnt);
        check("raw_valid", ex_valid, 0);
        stall = 1'b1;
        step();
        check("raw_stall_cnt", stall_count, exp_cnt);
        stall = 1'b0;
        repeat (int'(16'hFFFF - exp_cnt)) step();
        check("sat_cnt", stall_count, 32'hFFFF);
        step();
        check("sat_hold", stall_count, 32'hFFFF);
        mem_reg_write = 1'b0;
        #1;
        check("raw_clear", hazard_stall, 0);
        step();
        check("raw_issue_valid", ex_valid, 1);
        check("raw_issue_a", ex_a, 32'h44);
`endif

        // Asynchronous reset mid-run
        check("pre_rst_valid", ex_valid, 1);
        reset_n = 1'b0;
        #2;
        check("arst_valid", ex_valid, 0);
        check("arst_a", ex_a, 0);
        check("arst_regwrite", ex_reg_write, 0);
        check("arst_op", ex_operation, 0);
        check("arst_cnt", stall_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
